// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Package : fetch_pkg
// Shared state encoding and constants for the instruction fetch unit.
// Revision: 1.0
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    localparam int c_PC_INCR    = 4;
    localparam int c_FIFO_DEPTH = 2;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : instruction_fetch_unit_if
// Program-memory read port and decoder handshake of the fetch unit.
// Revision  : 1.0
// ============================================================================
interface instruction_fetch_unit_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic [DATA_WIDTH-1:0] Address_o;
    logic [DATA_WIDTH-1:0] Instruction_i;
    logic [DATA_WIDTH-1:0] instr_o;
    logic [DATA_WIDTH-1:0] instr_pc_o;
    logic                  instr_valid_o;
    logic                  instr_ready_i;

    modport master (
        output Address_o,
        input  Instruction_i,
        output instr_o,
        output instr_pc_o,
        output instr_valid_o,
        input  instr_ready_i
    );

    modport slave (
        input  Address_o,
        output Instruction_i,
        input  instr_o,
        input  instr_pc_o,
        input  instr_valid_o,
        output instr_ready_i
    );

endinterface : instruction_fetch_unit_if
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fetch_fifo
// Small {pc, instruction} FIFO with push, pop and flush; head is registered.
// Revision: 1.0
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic             i_flush,
    input  wire logic [WIDTH-1:0] i_data,
    output logic      [WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int c_PTR_W = $clog2(c_FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(c_FIFO_DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [c_FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == c_CNT_W'(c_FIFO_DEPTH));
    assign o_empty = (r_count == '0);

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : instruction_fetch_unit
// Sequential instruction fetch with redirect, range fault and 2-entry buffer.
// Revision: 1.0
// ============================================================================
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 64,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = '0
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  en_i,
    input  wire logic                  redirect_i,
    input  wire logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic      [DATA_WIDTH-1:0] pc_o,
    output logic                       fault_o,
    instruction_fetch_unit_if.master   bus
);

    localparam logic [DATA_WIDTH-1:0] c_SPAN = DATA_WIDTH'(c_PC_INCR * MEMORY_DEPTH);
    localparam logic [DATA_WIDTH-1:0] c_INCR = DATA_WIDTH'(c_PC_INCR);

    fetch_state_t          r_state;
    fetch_state_t          w_state_next;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] w_pc_next;
    logic [DATA_WIDTH-1:0] w_off;
    logic                  w_oor;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;

    // The offset is taken modulo 2^DATA_WIDTH, so a pc below BASE_ADDR is also caught explicitly.
    assign w_off = r_pc - BASE_ADDR;
    assign w_oor = (r_pc < BASE_ADDR) || (w_off >= c_SPAN) || (r_pc[1:0] != 2'b00);

    assign w_pop = bus.instr_valid_o && bus.instr_ready_i && !redirect_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pc    <= BASE_ADDR;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_push       = 1'b0;
        if (redirect_i) begin
            w_pc_next    = redirect_pc_i;
            w_state_next = en_i ? ST_FETCH : ST_IDLE;
        end else if (!en_i) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_FETCH;
                end
                ST_FETCH: begin
                    if (w_oor) begin
                        w_state_next = ST_FAULT;
                    end else if (!w_full || w_pop) begin
                        w_push    = 1'b1;
                        w_pc_next = r_pc + c_INCR;
                    end
                end
                ST_FAULT: begin
                    w_state_next = ST_FAULT;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH (2 * DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .i_data  ({r_pc, bus.Instruction_i}),
        .o_data  ({bus.instr_pc_o, bus.instr_o}),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.instr_valid_o = !w_empty;
    assign bus.Address_o     = w_off >> 2;
    assign pc_o              = r_pc;
    assign fault_o           = (r_state == ST_FAULT);

endmodule : instruction_fetch_unit
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_instruction_fetch_unit
// Self-checking bench: queue-based reference model plus directed literal checks.
// Revision: 1.0
// ============================================================================
module tb_instruction_fetch_unit;

    localparam int          DW    = 32;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_FAULT = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          en_i;
    logic          redirect_i;
    logic [DW-1:0] redirect_pc_i;
    logic [DW-1:0] pc_o;
    logic          fault_o;
    logic [31:0]   mem [DEPTH];

    int total = 0;
    int bad   = 0;

    ent_t        q[$];
    logic [31:0] mpc;
    int          mmode;

    instruction_fetch_unit_if #(.DATA_WIDTH(DW)) bus ();

    instruction_fetch_unit #(
        .DATA_WIDTH   (DW),
        .MEMORY_DEPTH (DEPTH),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .en_i          (en_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .pc_o          (pc_o),
        .fault_o       (fault_o),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    assign bus.Instruction_i = (bus.Address_o < DEPTH) ? mem[bus.Address_o[5:0]] : 32'hDEAD_BEEF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit out_of_range(input logic [31:0] pc);
        longint off;
        off = longint'(pc) - longint'(BASE);
        return (off < 0) || (off >= longint'(4 * DEPTH)) || ((pc % 4) != 0);
    endfunction

    task automatic model_reset();
        q.delete();
        mpc   = BASE;
        mmode = M_IDLE;
    endtask

    // Advance the reference by one clock edge using the inputs currently applied.
    task automatic model_step();
        ent_t e;
        bit   pop;
        pop = (q.size() > 0) && bus.instr_ready_i;
        if (redirect_i) begin
            q.delete();
            mpc   = redirect_pc_i;
            mmode = en_i ? M_FETCH : M_IDLE;
        end else begin
            if (pop) void'(q.pop_front());
            if (!en_i) begin
                mmode = M_IDLE;
            end else if (mmode == M_IDLE) begin
                mmode = M_FETCH;
            end else if (mmode == M_FETCH) begin
                if (out_of_range(mpc)) begin
                    mmode = M_FAULT;
                end else if (q.size() < 2) begin
                    e.pc  = mpc;
                    e.ins = mem[(mpc - BASE) / 4];
                    q.push_back(e);
                    mpc = mpc + 32'd4;
                end
            end
        end
    endtask

    task automatic model_check();
        chk("valid", {31'd0, bus.instr_valid_o}, {31'd0, q.size() != 0});
        chk("pc", pc_o, mpc);
        chk("fault", {31'd0, fault_o}, {31'd0, mmode == M_FAULT});
        chk("addr", bus.Address_o, (mpc - BASE) >> 2);
        if (q.size() != 0) begin
            chk("instr", bus.instr_o, q[0].ins);
            chk("instr_pc", bus.instr_pc_o, q[0].pc);
        end
    endtask

    task automatic tick(input logic en, input logic rdy, input logic redir, input logic [31:0] rpc);
        en_i              = en;
        bus.instr_ready_i = rdy;
        redirect_i        = redir;
        redirect_pc_i     = rpc;
        model_step();
        @(negedge clk);
        model_check();
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        en_i              = 1'b0;
        bus.instr_ready_i = 1'b0;
        redirect_i        = 1'b0;
        redirect_pc_i     = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] last_pc;
        logic [31:0] tgt;

        for (int k = 0; k < DEPTH; k++) mem[k] = 32'hA000_0000 + k;

        do_reset();
        chk("rst_valid", {31'd0, bus.instr_valid_o}, 32'd0);
        chk("rst_fault", {31'd0, fault_o}, 32'd0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_addr", bus.Address_o, 32'h0);
        chk("rst_instr", bus.instr_o, 32'h0);
        chk("rst_instr_pc", bus.instr_pc_o, 32'h0);

        // Streaming fetch with the decoder always ready.
        tick(1, 1, 0, 0);
        chk("s0_valid", {31'd0, bus.instr_valid_o}, 32'd0);
        tick(1, 1, 0, 0);
        chk("s1_instr", bus.instr_o, 32'hA000_0000);
        chk("s1_pc", bus.instr_pc_o, 32'h0);
        tick(1, 1, 0, 0);
        chk("s2_instr", bus.instr_o, 32'hA000_0001);
        chk("s2_pc", bus.instr_pc_o, 32'h4);
        tick(1, 1, 0, 0);
        chk("s3_instr", bus.instr_o, 32'hA000_0002);
        chk("s3_pc", bus.instr_pc_o, 32'h8);

        // Decoder stall: buffer fills, pc stalls, head held.
        do_reset();
        tick(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1, 0, 0, 0);
            chk("stall_head", bus.instr_o, 32'hA000_0000);
        end
        chk("stall_pc", pc_o, 32'h8);
        for (int i = 1; i <= 3; i++) begin
            tick(1, 1, 0, 0);
            chk("release_pc", bus.instr_pc_o, 32'(4 * i));
            chk("release_instr", bus.instr_o, 32'hA000_0000 + 32'(i));
        end

        // Redirect with a full buffer and ready high.
        tick(1, 1, 1, 32'h40);
        chk("redir_empty", {31'd0, bus.instr_valid_o}, 32'd0);
        chk("redir_pc", pc_o, 32'h40);
        tick(1, 1, 0, 0);
        chk("redir_head_pc", bus.instr_pc_o, 32'h40);
        chk("redir_head", bus.instr_o, 32'hA000_0010);

        // Run off the end of memory.
        tick(1, 1, 1, 32'hF0);
        last_pc = 32'hFFFF_FFFF;
        for (int i = 0; i < 12 && !fault_o; i++) begin
            tick(1, 1, 0, 0);
            if (bus.instr_valid_o) last_pc = bus.instr_pc_o;
        end
        chk("end_fault", {31'd0, fault_o}, 32'd1);
        chk("end_last_pc", last_pc, 32'hFC);
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 0, 0);
            chk("end_no_push", {31'd0, bus.instr_valid_o}, 32'd0);
            chk("end_pc", pc_o, 32'h100);
        end

        // Misaligned target, then recovery.
        tick(1, 1, 1, 32'h6);
        chk("mis_fault0", {31'd0, fault_o}, 32'd0);
        tick(1, 1, 0, 0);
        chk("mis_fault1", {31'd0, fault_o}, 32'd1);
        tick(1, 1, 1, 32'h0);
        chk("rec_fault", {31'd0, fault_o}, 32'd0);
        tick(1, 1, 0, 0);
        chk("rec_pc", bus.instr_pc_o, 32'h0);
        chk("rec_instr", bus.instr_o, 32'hA000_0000);

        // Asynchronous reset with two entries buffered.
        tick(1, 0, 0, 0);
        chk("pre_rst_valid", {31'd0, bus.instr_valid_o}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_valid", {31'd0, bus.instr_valid_o}, 32'd0);
        chk("async_pc", pc_o, BASE);
        do_reset();
        model_check();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0:       tgt = BASE + 32'({$urandom_range(0, DEPTH - 1), 2'b00});
                1:       tgt = BASE + 32'hF0 + 32'(4 * $urandom_range(0, 3));
                2:       tgt = 32'($urandom_range(0, 300));
                default: tgt = $urandom;
            endcase
            tick($urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0,
                 tgt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instruction_fetch_unit
`default_nettype wire
